// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Data-side memory controller sitting directly behind the CPU load/store path.
// It services single-cycle read/write strobes against an internal word RAM and
// a small memory-mapped I/O window. Load data comes back with a fixed latency
// of one cycle.
//
// I/O window, starting at IO_BASE:
//   +0 GPIO_OUT  R/W  output register, low GPIO_W bits of wdata
//   +1 GPIO_IN   RO   two-flop synchronised gpio_in, zero-extended
//   +2 CYCLES    R/W  free-running 32-bit counter; a write loads it
//   +3 STATUS    R/W  bit0 err, bit1 last error was a collision; wdata[0]=1 clears
//   +4..         unmapped: reads return 0, writes are dropped, both set err
//
// Ports:
//   clk       rising-edge system clock
//   rst       asynchronous active-low reset
//   write     store strobe, one cycle per store
//   read      load strobe, one cycle per load
//   address   word address
//   wdata     store data
//   rdata     load data, held until the next accepted read
//   rvalid    one-cycle pulse when rdata has been updated by a read
//   gpio_out  GPIO output register
//   gpio_in   asynchronous GPIO inputs
//   err       sticky error flag (STATUS[0])
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 8'hF0,
  parameter int                GPIO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              err
);

  localparam int RAM_DEPTH = int'(IO_BASE);
  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] A_GPO  = IO_BASE;
  localparam logic [ADDR_W-1:0] A_GPI  = IO_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CYC  = IO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STAT = IO_BASE + ADDR_W'(3);

  typedef enum logic [2:0] {
    REG_RAM  = 3'd0,
    REG_GPO  = 3'd1,
    REG_GPI  = 3'd2,
    REG_CYC  = 3'd3,
    REG_STAT = 3'd4,
    REG_NONE = 3'd5
  } region_e;

  // Word storage; deliberately not reset.
  logic [DATA_W-1:0] mem [RAM_DEPTH];

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_sync1_q, gpio_sync2_q;
  logic [31:0]       cycles_q, cycles_d;
  logic              err_q, err_d;
  logic              coll_q, coll_d;

  region_e           region_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic              ram_we_s;
  logic              collision_s;
  logic              err_set_s;
  logic              stat_clr_s;

  assign ram_idx_s   = address[RAM_AW-1:0];
  assign collision_s = read & write;

  // Address decode into one of the mapped regions.
  always_comb begin
    region_s = REG_NONE;
    if (address < IO_BASE) begin
      region_s = REG_RAM;
    end else if (address == A_GPO) begin
      region_s = REG_GPO;
    end else if (address == A_GPI) begin
      region_s = REG_GPI;
    end else if (address == A_CYC) begin
      region_s = REG_CYC;
    end else if (address == A_STAT) begin
      region_s = REG_STAT;
    end else begin
      region_s = REG_NONE;
    end
  end

  // Next-state logic for the write path, the read path and STATUS.
  always_comb begin
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    gpio_out_d = gpio_out_q;
    cycles_d   = cycles_q + 32'd1;
    err_d      = err_q;
    coll_d     = coll_q;
    ram_we_s   = 1'b0;
    err_set_s  = 1'b0;
    stat_clr_s = 1'b0;

    // A write is always performed, even when it collides with a read.
    if (write) begin
      case (region_s)
        REG_RAM:  ram_we_s   = 1'b1;
        REG_GPO:  gpio_out_d = wdata[GPIO_W-1:0];
        REG_GPI:  ram_we_s   = 1'b0;        // read-only, silently ignored
        REG_CYC:  cycles_d   = wdata[31:0]; // load beats the increment
        REG_STAT: stat_clr_s = wdata[0];
        default:  err_set_s  = 1'b1;
      endcase
    end else begin
      ram_we_s = 1'b0;
    end

    // A read is only accepted on its own; colliding reads are dropped.
    // The RAM is read combinationally, so a read right after a write to
    // the same word already sees the new data.
    if (read && !write) begin
      rvalid_d = 1'b1;
      case (region_s)
        REG_RAM:  rdata_d = mem[ram_idx_s];
        REG_GPO:  rdata_d = DATA_W'(gpio_out_q);
        REG_GPI:  rdata_d = DATA_W'(gpio_sync2_q);
        REG_CYC:  rdata_d = DATA_W'(cycles_q);
        REG_STAT: rdata_d = DATA_W'({coll_q, err_q});
        default: begin
          rdata_d   = '0;
          err_set_s = 1'b1;
        end
      endcase
    end else begin
      rvalid_d = 1'b0;
    end

    // Any error source beats a clear arriving in the same cycle; bit1
    // records whether the most recent error was a collision.
    if (collision_s) begin
      err_d  = 1'b1;
      coll_d = 1'b1;
    end else if (err_set_s) begin
      err_d  = 1'b1;
      coll_d = 1'b0;
    end else if (stat_clr_s) begin
      err_d  = 1'b0;
      coll_d = 1'b0;
    end else begin
      err_d  = err_q;
      coll_d = coll_q;
    end
  end

  // Control and I/O registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      gpio_out_q   <= '0;
      gpio_sync1_q <= '0;
      gpio_sync2_q <= '0;
      cycles_q     <= 32'd0;
      err_q        <= 1'b0;
      coll_q       <= 1'b0;
    end else begin
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      gpio_out_q   <= gpio_out_d;
      gpio_sync1_q <= gpio_in;
      gpio_sync2_q <= gpio_sync1_q;
      cycles_q     <= cycles_d;
      err_q        <= err_d;
      coll_q       <= coll_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem[ram_idx_s] <= wdata;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign gpio_out = gpio_out_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        write;
  logic        read;
  logic [7:0]  address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in;
  logic        err;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .read     (read),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    write   = 1'b1;
    read    = 1'b0;
    address = a;
    wdata   = d;
    tick();
    write   = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    read    = 1'b1;
    write   = 1'b0;
    address = a;
    tick();
    read    = 1'b0;
  endtask

  task automatic do_collide(input logic [7:0] a, input logic [31:0] d);
    read    = 1'b1;
    write   = 1'b1;
    address = a;
    wdata   = d;
    tick();
    read    = 1'b0;
    write   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b0;
    write   = 1'b0;
    read    = 1'b0;
    address = 8'h00;
    wdata   = 32'h0;
    gpio_in = 16'h0000;

    // Reset state
    idle(2);
    check("rst_rdata",    rdata,          32'h0);
    check("rst_rvalid",   32'(rvalid),    32'h0);
    check("rst_gpio_out", 32'(gpio_out),  32'h0);
    check("rst_err",      32'(err),       32'h0);
    rst = 1'b1;
    idle(1);

    // RAM write then back-to-back read, 1-cycle latency, data held
    do_write(8'h10, 32'hDEADBEEF);
    check("wr_no_rvalid", 32'(rvalid), 32'h0);
    do_read(8'h10);
    check("rd_rvalid",    32'(rvalid), 32'h1);
    check("rd_data",      rdata,       32'hDEADBEEF);
    address = 8'hxx;
    wdata   = 32'hxxxxxxxx;
    idle(1);
    check("rvalid_pulse", 32'(rvalid), 32'h0);
    check("rdata_held",   rdata,       32'hDEADBEEF);

    // Last RAM word
    do_write(8'hEF, 32'h13579BDF);
    do_read(8'hEF);
    check("ram_last", rdata, 32'h13579BDF);

    // GPIO out (upper wdata bits ignored) and synchronised GPIO in
    do_write(8'hF0, 32'hABCD1234);
    check("gpio_out", 32'(gpio_out), 32'h00001234);
    gpio_in = 16'hA5A5;
    idle(2);
    do_read(8'hF1);
    check("gpio_in_rd", rdata, 32'h0000A5A5);
    do_read(8'hF0);
    check("gpio_out_rd", rdata, 32'h00001234);
    do_write(8'hF1, 32'h00000000);
    check("gpi_wr_no_err", 32'(err), 32'h0);
    do_read(8'hF1);
    check("gpi_wr_ignored", rdata, 32'h0000A5A5);

    // Cycle counter wrap
    do_write(8'hF2, 32'hFFFFFFFE);
    idle(2);
    do_read(8'hF2);
    check("cyc_wrap", rdata, 32'h00000000);
    do_read(8'hF2);
    check("cyc_inc",  rdata, 32'h00000001);
    check("cyc_no_err", 32'(err), 32'h0);

    // Read/write collision
    do_collide(8'h05, 32'h00000007);
    check("coll_rvalid", 32'(rvalid), 32'h0);
    check("coll_err",    32'(err),    32'h1);
    check("coll_rdata",  rdata,       32'h00000001);
    do_read(8'h05);
    check("coll_wr_done", rdata, 32'h00000007);
    do_read(8'hF3);
    check("coll_status", rdata, 32'h00000003);
    do_write(8'hF3, 32'h00000001);
    check("clr_err", 32'(err), 32'h0);
    do_read(8'hF3);
    check("clr_status", rdata, 32'h00000000);

    // Unmapped access
    do_read(8'hF8);
    check("unmap_rdata",  rdata,       32'h00000000);
    check("unmap_rvalid", 32'(rvalid), 32'h1);
    check("unmap_err",    32'(err),    32'h1);
    do_read(8'hF3);
    check("unmap_status", rdata, 32'h00000001);
    do_write(8'hF8, 32'hFFFFFFFF);
    check("unmap_wr_gpio", 32'(gpio_out), 32'h00001234);
    do_read(8'hF0);
    check("unmap_wr_gpo_rd", rdata, 32'h00001234);
    do_read(8'h10);
    check("unmap_wr_ram10", rdata, 32'hDEADBEEF);
    do_read(8'h05);
    check("unmap_wr_ram05", rdata, 32'h00000007);

    // Set beats clear in the same cycle
    do_collide(8'hF3, 32'h00000001);
    check("set_wins_err", 32'(err), 32'h1);
    do_read(8'hF3);
    check("set_wins_status", rdata, 32'h00000003);
    do_write(8'hF3, 32'h00000001);
    check("clr_again", 32'(err), 32'h0);

    // Asynchronous reset while rvalid is high
    do_read(8'hF8);
    check("pre_rst_rvalid", 32'(rvalid), 32'h1);
    check("pre_rst_err",    32'(err),    32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rvalid",   32'(rvalid),   32'h0);
    check("async_gpio_out", 32'(gpio_out), 32'h0);
    check("async_err",      32'(err),      32'h0);
    check("async_rdata",    rdata,         32'h0);
    rst = 1'b1;
    do_read(8'h10);
    check("ram_retained", rdata, 32'hDEADBEEF);
    check("post_rst_gpio", 32'(gpio_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
